id_issue_ctrl: RTL and testbench

//  Issue controller between instruction decode and execute. It holds one decoded

---
 rtl/id_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_id_issue_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
// Decode-to-execute issue controller: one-entry output register, 32-entry pending-write
// scoreboard, RAW/WAW and serializing-op stalls, flush and a saturating stall counter.
module id_issue_ctrl #(
    parameter int NREGS       = 32,
    parameter int REG_IDX_W   = $clog2(NREGS),
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [PAYLOAD_W-1:0]   i_id_payload,
    input  logic [REG_IDX_W-1:0]   i_rs1,
    input  logic [REG_IDX_W-1:0]   i_rs2,
    input  logic                   i_use_rs1,
    input  logic                   i_use_rs2,
    input  logic [REG_IDX_W-1:0]   i_rd,
    input  logic                   i_wr_rd,
    input  logic                   i_serialize,
    output logic                   o_ex_valid,
    input  logic                   i_ex_ready,
    output logic [PAYLOAD_W-1:0]   o_ex_payload,
    output logic [REG_IDX_W-1:0]   o_ex_rd,
    output logic                   o_ex_wr_rd,
    input  logic                   i_wb_valid,
    input  logic [REG_IDX_W-1:0]   i_wb_rd,
    input  logic                   i_flush,
    output logic [NREGS-1:0]       o_pending,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic                   ex_valid_reg;
    logic [PAYLOAD_W-1:0]   ex_payload_reg;
    logic [REG_IDX_W-1:0]   ex_rd_reg;
    logic                   ex_wr_rd_reg;
    logic [NREGS-1:0]       pending_reg, pending_next;
    logic [NREGS-1:0]       busy, set_vec, clr_vec;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    logic                   hazard, slot_free, id_ready, accept, ex_hs, stall_inc;

    assign ex_hs     = ex_valid_reg & i_ex_ready;
    assign slot_free = ~ex_valid_reg | i_ex_ready;
    assign accept    = i_id_valid & id_ready;
    assign stall_inc = i_id_valid & ~id_ready & ~i_flush;

    // A register is busy while its writer is pending or still sitting in the output register.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sb
            if (gi == 0) begin : g_x0
                assign busy[gi]    = 1'b0;
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
            end else begin : g_xn
                localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(gi);
                assign busy[gi]    = pending_reg[gi] | (ex_valid_reg & ex_wr_rd_reg & (ex_rd_reg == IDX));
                assign set_vec[gi] = ex_hs & ex_wr_rd_reg & (ex_rd_reg == IDX);
                assign clr_vec[gi] = i_wb_valid & (i_wb_rd == IDX);
            end
        end
    endgenerate

    // Set is applied after clear so a new writer wins over a same-cycle retirement.
    assign pending_next = (pending_reg & ~clr_vec) | set_vec;

    assign hazard = (i_use_rs1 & busy[i_rs1]) |
                    (i_use_rs2 & busy[i_rs2]) |
                    (i_wr_rd   & busy[i_rd]);

    always_comb begin
        state_next = state_reg;
        id_ready   = 1'b0;
        case (state_reg)
            ST_RUN: begin
                id_ready = slot_free & ~hazard & ~i_serialize & ~i_flush;
                if (i_id_valid & i_serialize & ~i_flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                id_ready = slot_free & ~ex_valid_reg & ~(|pending_reg) & ~i_flush;
                if ((i_id_valid & id_ready) | i_flush) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_RUN;
            ex_valid_reg   <= 1'b0;
            ex_payload_reg <= '0;
            ex_rd_reg      <= '0;
            ex_wr_rd_reg   <= 1'b0;
            pending_reg    <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            if (i_flush) begin
                ex_valid_reg <= 1'b0;
            end else if (accept) begin
                ex_valid_reg   <= 1'b1;
                ex_payload_reg <= i_id_payload;
                ex_rd_reg      <= i_rd;
                ex_wr_rd_reg   <= i_wr_rd;
            end else if (ex_hs) begin
                ex_valid_reg <= 1'b0;
            end
            if (stall_inc && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
            end
        end
    end

    assign o_id_ready   = id_ready;
    assign o_ex_valid   = ex_valid_reg;
    assign o_ex_payload = ex_payload_reg;
    assign o_ex_rd      = ex_rd_reg;
    assign o_ex_wr_rd   = ex_wr_rd_reg;
    assign o_pending    = pending_reg;
    assign o_stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: vector table, hand-written corner sequences, then random
// stimulus against a scoreboard-level reference model.
module tb_id_issue_ctrl;

    logic        i_clk, i_rst_n;
    logic        i_id_valid, o_id_ready;
    logic [63:0] i_id_payload;
    logic [4:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
    logic        i_use_rs1, i_use_rs2, i_wr_rd, i_serialize;
    logic        o_ex_valid, i_ex_ready, o_ex_wr_rd;
    logic [63:0] o_ex_payload;
    logic [4:0]  o_ex_rd;
    logic        i_wb_valid, i_flush;
    logic [31:0] o_pending;
    logic [15:0] o_stall_cnt;

    id_issue_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_valid(i_id_valid), .o_id_ready(o_id_ready), .i_id_payload(i_id_payload),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_use_rs1(i_use_rs1), .i_use_rs2(i_use_rs2),
        .i_rd(i_rd), .i_wr_rd(i_wr_rd), .i_serialize(i_serialize),
        .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_payload(o_ex_payload),
        .o_ex_rd(o_ex_rd), .o_ex_wr_rd(o_ex_wr_rd),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_flush(i_flush),
        .o_pending(o_pending), .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_id_valid = 0; i_id_payload = '0; i_rs1 = 0; i_rs2 = 0; i_use_rs1 = 0; i_use_rs2 = 0;
        i_rd = 0; i_wr_rd = 0; i_serialize = 0; i_ex_ready = 1; i_wb_valid = 0; i_wb_rd = 0;
        i_flush = 0;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic wr, input logic ser, input logic [63:0] pay);
        i_id_valid = 1; i_use_rs1 = 0; i_use_rs2 = 0; i_rs1 = 0; i_rs2 = 0;
        i_rd = rd; i_wr_rd = wr; i_serialize = ser; i_id_payload = pay;
    endtask

    task automatic do_reset();
        idle();
        i_rst_n = 0;
        tick();
        tick();
        i_rst_n = 1;
    endtask

    typedef struct {
        logic        v;  logic [4:0] rs1; logic u1; logic [4:0] rd; logic wr;
        logic        exr; logic wbv; logic [4:0] wbrd; logic [63:0] pay;
        logic        e_ready; logic e_exv; logic [4:0] e_rd; logic [63:0] e_pay;
        logic [31:0] e_pend; logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rd, input logic wr, input logic exr,
                                input logic wbv, input logic [4:0] wbrd, input logic [63:0] pay,
                                input logic e_ready, input logic e_exv, input logic [4:0] e_rd,
                                input logic [63:0] e_pay, input logic [31:0] e_pend,
                                input logic [15:0] e_stall);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.u1 = u1; r.rd = rd; r.wr = wr; r.exr = exr; r.wbv = wbv;
        r.wbrd = wbrd; r.pay = pay; r.e_ready = e_ready; r.e_exv = e_exv; r.e_rd = e_rd;
        r.e_pay = e_pay; r.e_pend = e_pend; r.e_stall = e_stall;
        return r;
    endfunction

    vec_t vecs[18];

    // Reference model: set of registers awaiting writeback plus the single held instruction.
    bit          m_pend[32];
    bit          m_exv, m_wr, m_drain;
    logic [63:0] m_pay;
    logic [4:0]  m_rd;
    int          m_stall;

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 0) return 0;
        return m_pend[r] || (m_exv && m_wr && m_rd == r);
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        v = '0;
        for (int k = 1; k < 32; k++) v[k] = m_pend[k];
        return v;
    endfunction

    function automatic bit model_ready();
        bit quiet;
        if (i_flush) return 0;
        if (m_drain) begin
            quiet = !m_exv;
            for (int k = 1; k < 32; k++) if (m_pend[k]) quiet = 0;
            return quiet;
        end
        if (i_serialize) return 0;
        if (m_exv && !i_ex_ready) return 0;
        if (i_use_rs1 && m_busy(i_rs1)) return 0;
        if (i_use_rs2 && m_busy(i_rs2)) return 0;
        if (i_wr_rd && m_busy(i_rd)) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit r);
        bit hs, acc;
        hs  = m_exv && i_ex_ready;
        acc = i_id_valid && r;
        if (i_wb_valid && i_wb_rd != 0) m_pend[i_wb_rd] = 0;
        if (hs && m_wr && m_rd != 0) m_pend[m_rd] = 1;
        if (!m_drain) begin
            if (i_id_valid && i_serialize && !i_flush) m_drain = 1;
        end else if (acc || i_flush) begin
            m_drain = 0;
        end
        if (i_id_valid && !r && !i_flush && m_stall < 65535) m_stall++;
        if (i_flush) m_exv = 0;
        else if (acc) begin
            m_exv = 1; m_pay = i_id_payload; m_rd = i_rd; m_wr = i_wr_rd;
        end else if (hs) m_exv = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit er;
        int issued;

        // Independent stream, RAW stall/wb, then EX backpressure.
        vecs[0]  = mk(1, 0, 0, 1, 1, 1, 0, 0, 64'h101, 1, 1, 1, 64'h101, 32'h00, 0);
        vecs[1]  = mk(1, 0, 0, 2, 1, 1, 0, 0, 64'h102, 1, 1, 2, 64'h102, 32'h02, 0);
        vecs[2]  = mk(1, 0, 0, 3, 1, 1, 0, 0, 64'h103, 1, 1, 3, 64'h103, 32'h06, 0);
        vecs[3]  = mk(1, 0, 0, 4, 1, 1, 0, 0, 64'h104, 1, 1, 4, 64'h104, 32'h0E, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h000, 1, 0, 4, 64'h104, 32'h1E, 0);
        vecs[5]  = mk(1, 0, 0, 5, 1, 1, 0, 0, 64'h105, 1, 1, 5, 64'h105, 32'h1E, 0);
        vecs[6]  = mk(1, 5, 1, 6, 1, 1, 0, 0, 64'h106, 0, 0, 5, 64'h105, 32'h3E, 1);
        vecs[7]  = mk(1, 5, 1, 6, 1, 1, 0, 0, 64'h106, 0, 0, 5, 64'h105, 32'h3E, 2);
        vecs[8]  = mk(1, 5, 1, 6, 1, 1, 1, 5, 64'h106, 0, 0, 5, 64'h105, 32'h1E, 3);
        vecs[9]  = mk(1, 5, 1, 6, 1, 1, 0, 0, 64'h106, 1, 1, 6, 64'h106, 32'h1E, 3);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h000, 1, 0, 6, 64'h106, 32'h5E, 3);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 64'h10C, 1, 1, 0, 64'h10C, 32'h5E, 3);
        for (int k = 12; k <= 16; k++)
            vecs[k] = mk(1, 0, 0, 7, 1, 0, 0, 0, 64'h10D, 0, 1, 0, 64'h10C, 32'h5E, 16'(k - 8));
        vecs[17] = mk(1, 0, 0, 7, 1, 1, 0, 0, 64'h10D, 1, 1, 7, 64'h10D, 32'h5E, 8);

        idle();
        i_rst_n = 0;
        tick();
        chk("reset_ex_valid", 64'(o_ex_valid), 0);
        chk("reset_payload", o_ex_payload, 0);
        chk("reset_rd", 64'(o_ex_rd), 0);
        chk("reset_wr_rd", 64'(o_ex_wr_rd), 0);
        chk("reset_pending", 64'(o_pending), 0);
        chk("reset_stall", 64'(o_stall_cnt), 0);
        $display("reset checked");
        i_rst_n = 1;

        for (int k = 0; k < 18; k++) begin
            idle();
            i_id_valid = vecs[k].v; i_rs1 = vecs[k].rs1; i_use_rs1 = vecs[k].u1;
            i_rd = vecs[k].rd; i_wr_rd = vecs[k].wr; i_ex_ready = vecs[k].exr;
            i_wb_valid = vecs[k].wbv; i_wb_rd = vecs[k].wbrd; i_id_payload = vecs[k].pay;
            #1;
            chk($sformatf("vec%0d_id_ready", k), 64'(o_id_ready), 64'(vecs[k].e_ready));
            tick();
            chk($sformatf("vec%0d_ex_valid", k), 64'(o_ex_valid), 64'(vecs[k].e_exv));
            chk($sformatf("vec%0d_ex_rd", k), 64'(o_ex_rd), 64'(vecs[k].e_rd));
            chk($sformatf("vec%0d_payload", k), o_ex_payload, vecs[k].e_pay);
            chk($sformatf("vec%0d_pending", k), 64'(o_pending), 64'(vecs[k].e_pend));
            chk($sformatf("vec%0d_stall", k), 64'(o_stall_cnt), 64'(vecs[k].e_stall));
            $display("vector %0d: ready=%0b ex_valid=%0b rd=%0d pending=%h stall=%0d",
                     k, vecs[k].e_ready, o_ex_valid, o_ex_rd, o_pending, o_stall_cnt);
        end

        // Serializing op waits in drain until x7 retires, then issues and RUN resumes.
        do_reset();
        drive_op(7, 1, 0, 64'h207);
        tick();
        idle();
        tick();
        chk("ser_pending7", 64'(o_pending), 32'h80);
        drive_op(0, 0, 1, 64'h2AA);
        #1 chk("ser_run_ready", 64'(o_id_ready), 0);
        tick();
        #1 chk("ser_drain_ready1", 64'(o_id_ready), 0);
        tick();
        i_wb_valid = 1; i_wb_rd = 7;
        #1 chk("ser_wb_cycle_ready", 64'(o_id_ready), 0);
        tick();
        i_wb_valid = 0;
        #1 chk("ser_drained_ready", 64'(o_id_ready), 1);
        tick();
        chk("ser_ex_valid", 64'(o_ex_valid), 1);
        chk("ser_payload", o_ex_payload, 64'h2AA);
        chk("ser_stall", 64'(o_stall_cnt), 3);
        drive_op(8, 1, 0, 64'h2BB);
        #1 chk("ser_back_to_run", 64'(o_id_ready), 1);
        tick();
        chk("ser_next_rd", 64'(o_ex_rd), 8);
        $display("serialize sequence: stall=%0d", o_stall_cnt);

        // Flush discards held op without scoreboarding it; incoming op is refused.
        idle();
        tick();
        drive_op(9, 1, 0, 64'h209);
        tick();
        chk("flush_pre_valid", 64'(o_ex_valid), 1);
        drive_op(10, 1, 0, 64'h20A);
        i_ex_ready = 0; i_flush = 1;
        #1 chk("flush_ready", 64'(o_id_ready), 0);
        tick();
        chk("flush_ex_valid", 64'(o_ex_valid), 0);
        chk("flush_pending", 64'(o_pending), 32'h100);
        chk("flush_stall", 64'(o_stall_cnt), 3);
        $display("flush sequence: pending=%h", o_pending);

        // Same-cycle set and clear of x3; x0 never tracked; stray writeback ignored.
        idle();
        drive_op(3, 1, 0, 64'h203);
        tick();
        idle();
        i_wb_valid = 1; i_wb_rd = 3;
        tick();
        chk("setclr_pending", 64'(o_pending), 32'h108);
        drive_op(0, 1, 0, 64'h200);
        i_wb_valid = 1; i_wb_rd = 0;
        tick();
        idle();
        i_wb_valid = 1; i_wb_rd = 0;
        tick();
        idle();
        i_wb_valid = 1; i_wb_rd = 20;
        tick();
        chk("x0_pending", 64'(o_pending), 32'h108);
        $display("set/clear sequence: pending=%h", o_pending);

        // Asynchronous reset in the middle of a busy stream.
        do_reset();
        for (int r = 1; r <= 15; r++) begin
            drive_op(5'(r), 1, 0, 64'h300 + 64'(r));
            tick();
        end
        drive_op(0, 0, 0, 64'h3FF);
        tick();
        drive_op(16, 1, 0, 64'h310);
        i_ex_ready = 0;
        tick();
        chk("mid_pending", 64'(o_pending), 32'hFFFE);
        chk("mid_ex_valid", 64'(o_ex_valid), 1);
        chk("mid_stall", 64'(o_stall_cnt), 1);
        #2 i_rst_n = 0;
        #1;
        chk("arst_ex_valid", 64'(o_ex_valid), 0);
        chk("arst_payload", o_ex_payload, 0);
        chk("arst_rd", 64'(o_ex_rd), 0);
        chk("arst_pending", 64'(o_pending), 0);
        chk("arst_stall", 64'(o_stall_cnt), 0);
        $display("async reset sequence done");
        idle();
        tick();
        i_rst_n = 1;

        // Random traffic against the reference model.
        for (int k = 0; k < 32; k++) m_pend[k] = 0;
        m_exv = 0; m_wr = 0; m_drain = 0; m_pay = '0; m_rd = 0; m_stall = 0;
        issued = 0;
        for (int c = 0; c < 2000; c++) begin
            i_id_valid   = ($urandom_range(0, 99) < 80);
            i_id_payload = {$urandom, $urandom};
            i_rs1        = 5'($urandom_range(0, 7));
            i_rs2        = 5'($urandom_range(0, 7));
            i_rd         = 5'($urandom_range(0, 7));
            i_use_rs1    = 1'($urandom_range(0, 1));
            i_use_rs2    = 1'($urandom_range(0, 1));
            i_wr_rd      = ($urandom_range(0, 99) < 75);
            i_serialize  = ($urandom_range(0, 99) < 4);
            i_ex_ready   = ($urandom_range(0, 99) < 70);
            i_wb_valid   = ($urandom_range(0, 99) < 40);
            i_wb_rd      = 5'($urandom_range(0, 7));
            i_flush      = ($urandom_range(0, 99) < 4);
            #1;
            er = model_ready();
            chk("rnd_id_ready", 64'(o_id_ready), 64'(er));
            if (i_id_valid && er) begin
                issued++;
                $display("rnd issue %0d: rd=%0d wr=%0b ser=%0b pay=%h",
                         issued, i_rd, i_wr_rd, i_serialize, i_id_payload);
            end
            model_step(er);
            tick();
            chk("rnd_ex_valid", 64'(o_ex_valid), 64'(m_exv));
            chk("rnd_pending", 64'(o_pending), 64'(m_pend_vec()));
            chk("rnd_stall", 64'(o_stall_cnt), 64'(m_stall));
            if (m_exv) begin
                chk("rnd_payload", o_ex_payload, m_pay);
                chk("rnd_ex_rd", 64'(o_ex_rd), 64'(m_rd));
                chk("rnd_ex_wr_rd", 64'(o_ex_wr_rd), 64'(m_wr));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
